// File: rtl/dmem_responder_pkg.sv
// Shared address-map constants, region decode and STATUS word packing for dmem_responder.
package dmem_responder_pkg;

    // MMIO window occupies the top 16 words of the address space.
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FFF0;

    // Word offsets inside the MMIO window.
    localparam logic [3:0]  OFF_CYCLE  = 4'd0;
    localparam logic [3:0]  OFF_TXDATA = 4'd1;
    localparam logic [3:0]  OFF_STATUS = 4'd2;
    localparam logic [3:0]  OFF_GPIO   = 4'd3;

    // STATUS register bit positions.
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 3;
    localparam int STAT_COUNT_W   = 5;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_e;

    // Unsigned decode: RAM below ram_words, MMIO in the top window, nothing else aliases.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_words);
        if (addr < ram_words) begin
            return REGION_RAM;
        end else if (addr[31:4] == MMIO_BASE[31:4]) begin
            return REGION_MMIO;
        end else begin
            return REGION_NONE;
        end
    endfunction

    // Pack FIFO state into the STATUS read word.
    function automatic logic [31:0] status_word(input logic [STAT_COUNT_W-1:0] count,
                                                input logic ovf,
                                                input logic full,
                                                input logic empty);
        logic [31:0] w;
        w = '0;
        w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        w[STAT_OVF_BIT]                   = ovf;
        w[STAT_FULL_BIT]                  = full;
        w[STAT_EMPTY_BIT]                 = empty;
        return w;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte TX FIFO: circular buffer with wrap-bit pointers, registered-state head output,
// and a one-cycle pulse when a push is dropped because the buffer is full.
module dmem_responder_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [7:0]    i_push_data,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count,
    output logic          o_push_dropped
);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Full when the index bits match and only the wrap bit differs.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = CW'(r_wr_ptr - r_rd_ptr);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees a slot in the same edge, so a push while full still fits if a pop happens.
    assign w_do_pop       = i_pop & ~o_empty;
    assign w_do_push      = i_push & (~o_full | w_do_pop);
    assign o_push_dropped = i_push & o_full & ~w_do_pop;

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointer update; reset empties the FIFO and ignores a concurrent push/pop.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM at low addresses plus an MMIO window holding a
// free-running cycle counter, a byte TX FIFO and a 16-bit GPIO register.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH    = 4096,
    parameter int TX_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] gpio_out
);

    localparam int RAM_AW = $clog2(DEPTH);
    localparam int TX_AW  = $clog2(TX_DEPTH);
    localparam int TX_CW  = TX_AW + 1;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_cycle;
    logic [15:0] r_gpio;
    logic        r_ovf;

    region_e          w_region;
    logic [3:0]       w_off;
    logic             w_wr_ram;
    logic             w_wr_mmio;
    logic             w_wr_cycle;
    logic             w_wr_status;
    logic             w_wr_gpio;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [TX_CW-1:0] w_count;
    logic             w_dropped;
    logic [7:0]       w_head;
    logic [31:0]      w_rdata;

    assign w_region = decode_region(address_dmem, 32'(DEPTH));
    assign w_off    = address_dmem[3:0];

    // Writes are suppressed while reset is high so a mid-operation reset leaves state clean.
    assign w_wr_ram    = wren & ~reset & (w_region == REGION_RAM);
    assign w_wr_mmio   = wren & ~reset & (w_region == REGION_MMIO);
    assign w_wr_cycle  = w_wr_mmio & (w_off == OFF_CYCLE);
    assign w_push      = w_wr_mmio & (w_off == OFF_TXDATA);
    assign w_wr_status = w_wr_mmio & (w_off == OFF_STATUS);
    assign w_wr_gpio   = w_wr_mmio & (w_off == OFF_GPIO);

    assign tx_valid = ~w_empty;
    assign tx_data  = w_head;
    assign w_pop    = tx_valid & tx_ready;
    assign gpio_out = r_gpio;

    dmem_responder_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_push         (w_push),
        .i_push_data    (data[7:0]),
        .i_pop          (w_pop),
        .o_head         (w_head),
        .o_empty        (w_empty),
        .o_full         (w_full),
        .o_count        (w_count),
        .o_push_dropped (w_dropped)
    );

    // RAM store; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_wr_ram) begin
            r_mem[address_dmem[RAM_AW-1:0]] <= data;
        end
    end

    // Cycle counter: a processor write takes priority over the free-running increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_wr_cycle) begin
            r_cycle <= data;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // GPIO output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gpio <= '0;
        end else if (w_wr_gpio) begin
            r_gpio <= data[15:0];
        end
    end

    // Sticky overflow flag: set by a dropped push, cleared by any STATUS write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_wr_status) begin
            r_ovf <= 1'b0;
        end else if (w_dropped) begin
            r_ovf <= 1'b1;
        end
    end

    // Combinational load mux; reads reflect pre-edge state and are forced to 0 in reset.
    always_comb begin
        w_rdata = '0;
        if (!reset) begin
            unique case (w_region)
                REGION_RAM: w_rdata = r_mem[address_dmem[RAM_AW-1:0]];
                REGION_MMIO: begin
                    unique case (w_off)
                        OFF_CYCLE:  w_rdata = r_cycle;
                        OFF_STATUS: w_rdata = status_word(STAT_COUNT_W'(w_count),
                                                          r_ovf, w_full, w_empty);
                        OFF_GPIO:   w_rdata = {16'b0, r_gpio};
                        default:    w_rdata = '0;
                    endcase
                end
                default: w_rdata = '0;
            endcase
        end
    end

    assign q_dmem = w_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table for RAM/decode/GPIO plus
// hand-written sequences for the counter, FIFO overflow, full push+pop and reset.
module tb_dmem_responder;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FFF0;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_FFF1;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FFF2;
    localparam logic [31:0] A_GPIO   = 32'hFFFF_FFF3;
    localparam logic [31:0] A_IDLE   = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] gpio_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH    (4096),
        .TX_DEPTH (8)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .gpio_out     (gpio_out)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        chk;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        @(negedge clk);
        address_dmem = a;
        data         = d;
        wren         = we;
        tx_ready     = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        address_dmem = A_CYCLE;
        data = '0;
        wren = 1'b0;
        tx_ready = 1'b0;

        vecs[0]  = '{"wr_ram0",       32'd0,          32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{"wr_ram5",       32'd5,          32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{"rd_ram5",       32'd5,          32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{"rd_depth",      32'd4096,       32'h0,         1'b0, 1'b1, 32'h0};
        vecs[4]  = '{"wr_depth",      32'd4096,       32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{"rd_ram0",       32'd0,          32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5};
        vecs[6]  = '{"wr_ram_top",    32'd4095,       32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{"rd_ram_top",    32'd4095,       32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{"wr_gpio",       A_GPIO,         32'h1234_ABCD, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{"rd_gpio",       A_GPIO,         32'h0,         1'b0, 1'b1, 32'h0000_ABCD};
        vecs[10] = '{"rd_txdata",     A_TXDATA,       32'h0,         1'b0, 1'b1, 32'h0};
        vecs[11] = '{"rd_mmio4",      32'hFFFF_FFF4,  32'h0,         1'b0, 1'b1, 32'h0};
        vecs[12] = '{"wr_mmio_ff",    32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
        vecs[13] = '{"rd_hole",       32'h8000_0000,  32'h0,         1'b0, 1'b1, 32'h0};
        vecs[14] = '{"wr_hole",       32'hFFFF_FFEF,  32'h5555_5555, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{"rd_status_idle",A_STATUS,       32'h0,         1'b0, 1'b1, 32'h0000_0001};

        // Reset state.
        cyc(A_CYCLE, 32'h0, 1'b0, 1'b0);
        cyc(A_CYCLE, 32'h0, 1'b0, 1'b0);
        chk("reset_q", q_dmem, 32'h0);
        chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("reset_gpio", {16'b0, gpio_out}, 32'h0);

        // Cycle counter from reset release.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("cycle_0", q_dmem, 32'd0);
        for (int i = 1; i <= 10; i++) cyc(A_CYCLE, 32'h0, 1'b0, 1'b0);
        chk("cycle_10", q_dmem, 32'd10);
        cyc(A_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cyc(A_CYCLE, 32'h0, 1'b0, 1'b0);
        chk("cycle_load", q_dmem, 32'hFFFF_FFFE);
        cyc(A_CYCLE, 32'h0, 1'b0, 1'b0);
        chk("cycle_inc", q_dmem, 32'hFFFF_FFFF);
        cyc(A_CYCLE, 32'h0, 1'b0, 1'b0);
        chk("cycle_wrap", q_dmem, 32'h0);

        // Table-driven RAM, decode and GPIO vectors.
        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0);
            if (vecs[i].chk) chk(vecs[i].name, q_dmem, vecs[i].exp_q);
        end
        chk("gpio_out", {16'b0, gpio_out}, 32'h0000_ABCD);

        // FIFO fill and overflow, then in-order drain.
        for (int i = 0; i < 9; i++) cyc(A_TXDATA, 32'hFFFF_FF41 + 32'(i), 1'b1, 1'b0);
        cyc(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("status_ovf_full", q_dmem, 32'h46);
        for (int i = 0; i < 8; i++) begin
            cyc(A_IDLE, 32'h0, 1'b0, 1'b1);
            chk($sformatf("drain_valid%0d", i), {31'b0, tx_valid}, 32'h1);
            chk($sformatf("drain_byte%0d", i), {24'b0, tx_data}, 32'h41 + 32'(i));
        end
        cyc(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("status_drained", q_dmem, 32'h05);
        cyc(A_STATUS, 32'h0, 1'b1, 1'b0);
        cyc(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("status_ovf_clr", q_dmem, 32'h01);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) cyc(A_TXDATA, 32'h61 + 32'(i), 1'b1, 1'b0);
        cyc(A_TXDATA, 32'h5A, 1'b1, 1'b1);
        chk("pp_head", {24'b0, tx_data}, 32'h61);
        cyc(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("pp_status", q_dmem, 32'h42);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] e;
            e = (i == 7) ? 32'h5A : 32'h62 + 32'(i);
            cyc(A_IDLE, 32'h0, 1'b0, 1'b1);
            chk($sformatf("pp_byte%0d", i), {24'b0, tx_data}, e);
        end
        cyc(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("pp_empty", q_dmem, 32'h01);

        // Push-to-valid latency, then mid-operation reset.
        cyc(A_TXDATA, 32'h33, 1'b1, 1'b0);
        chk("push_no_fallthru", {31'b0, tx_valid}, 32'h0);
        cyc(A_TXDATA, 32'h34, 1'b1, 1'b0);
        chk("push_valid", {31'b0, tx_valid}, 32'h1);
        chk("push_head", {24'b0, tx_data}, 32'h33);
        cyc(A_TXDATA, 32'h35, 1'b1, 1'b0);
        cyc(A_GPIO, 32'h0000_FFFF, 1'b1, 1'b0);
        cyc(32'd9, 32'h9988_7766, 1'b1, 1'b0);
        cyc(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_status", q_dmem, 32'h18);
        chk("pre_rst_gpio", {16'b0, gpio_out}, 32'h0000_FFFF);
        @(negedge clk);
        reset = 1'b1;
        address_dmem = A_TXDATA;
        data = 32'h77;
        wren = 1'b1;
        #1;
        chk("rst_q_forced", q_dmem, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        address_dmem = A_STATUS;
        wren = 1'b0;
        #1;
        chk("post_rst_valid", {31'b0, tx_valid}, 32'h0);
        chk("post_rst_status", q_dmem, 32'h01);
        chk("post_rst_gpio", {16'b0, gpio_out}, 32'h0);
        cyc(32'd9, 32'h0, 1'b0, 1'b0);
        chk("post_rst_ram9", q_dmem, 32'h9988_7766);
        cyc(32'd5, 32'h0, 1'b0, 1'b0);
        chk("post_rst_ram5", q_dmem, 32'hDEAD_BEEF);

        // A read of a populated RAM word during reset is forced to zero.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_q_ram5", q_dmem, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_rst_ram5", q_dmem, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
